// File: rtl/pmod_link_pkg.sv
// Shared types and constants for the inter-board Pmod position link.
package pmod_link_pkg;

  localparam int unsigned DefXw      = 12;
  localparam int unsigned DefYw      = 12;
  localparam int unsigned ScreenXMax = 1023;
  localparam int unsigned ScreenYMax = 767;

  typedef enum logic [1:0] {
    StAcquire,
    StLocked,
    StLost
  } link_state_e;

  // Extracts a field of up to 32 bits from a packed bus word.
  function automatic logic [31:0] unpack_field(input logic [63:0] word,
                                               input int unsigned lsb,
                                               input int unsigned width);
    logic [63:0] mask;
    mask = (64'd1 << width) - 64'd1;
    return 32'((word >> lsb) & mask);
  endfunction

endpackage

// File: rtl/bus_sync.sv
// Multi-flop synchroniser for a parallel bus, cleared by asynchronous reset.
module bus_sync #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync_q [STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= d;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pmod_pos_link_rx.sv
// Master-board position receiver: re-times the local position and captures a debounced,
// range-checked remote position from the asynchronous Pmod bus, tracking link health.
module pmod_pos_link_rx
  import pmod_link_pkg::*;
#(
  parameter int unsigned XW            = DefXw,
  parameter int unsigned YW            = DefYw,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned X_MAX         = ScreenXMax,
  parameter int unsigned Y_MAX         = ScreenYMax,
  parameter int unsigned ERR_LIMIT     = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [XW+YW-1:0] pmod_in,
  input  logic [XW-1:0] xpos_in_local,
  input  logic [YW-1:0] ypos_in_local,
  output logic [XW-1:0] xpos_out_local,
  output logic [YW-1:0] ypos_out_local,
  output logic [XW-1:0] xpos_out_remote,
  output logic [YW-1:0] ypos_out_remote,
  output logic          remote_valid,
  output logic          link_lost,
  output logic          remote_update,
  output logic [7:0]    rx_errors
);

  localparam int unsigned W    = XW + YW;
  localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned ErrW = $clog2(ERR_LIMIT + 1);

  logic [W-1:0]    s, prev_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [ErrW-1:0] err_run_q, err_run_d;
  logic [XW-1:0]   x_s, xr_q, xl_q;
  logic [YW-1:0]   y_s, yr_q, yl_q;
  logic [7:0]      rx_q;
  logic            ev, in_range, accept, reject, lost_hit;
  logic            valid_q, lost_q, update_q;
  link_state_e     state_q, state_d;

  bus_sync #(
    .WIDTH  (W),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (pmod_in),
    .q   (s)
  );

  assign x_s      = XW'(unpack_field(64'(s), 0, XW));
  assign y_s      = YW'(unpack_field(64'(s), XW, YW));
  assign in_range = (32'(x_s) <= X_MAX) && (32'(y_s) <= Y_MAX);

  // Event fires only on the step into saturation, so once per distinct stable word.
  assign ev     = (s == prev_q) && (cnt_q == CntW'(STABLE_CYCLES - 1));
  assign accept = ev && in_range;
  assign reject = ev && !in_range;

  always_comb begin
    cnt_d = cnt_q;
    if (s != prev_q) begin
      cnt_d = '0;
    end else if (cnt_q != CntW'(STABLE_CYCLES)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    err_run_d = err_run_q;
    if (accept) begin
      err_run_d = '0;
    end else if (reject && err_run_q != ErrW'(ERR_LIMIT)) begin
      err_run_d = err_run_q + 1'b1;
    end
  end

  assign lost_hit = reject && (32'(err_run_d) == ERR_LIMIT);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StAcquire: begin
        if (accept) state_d = StLocked;
        else if (lost_hit) state_d = StLost;
      end
      StLocked: if (lost_hit) state_d = StLost;
      StLost:   if (accept) state_d = StLocked;
      default:  state_d = StAcquire;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StAcquire;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q    <= '0;
      cnt_q     <= '0;
      err_run_q <= '0;
      xr_q      <= '0;
      yr_q      <= '0;
      xl_q      <= '0;
      yl_q      <= '0;
      rx_q      <= '0;
      valid_q   <= 1'b0;
      lost_q    <= 1'b0;
      update_q  <= 1'b0;
    end else begin
      prev_q    <= s;
      cnt_q     <= cnt_d;
      err_run_q <= err_run_d;
      xl_q      <= xpos_in_local;
      yl_q      <= ypos_in_local;
      valid_q   <= (state_d == StLocked);
      lost_q    <= (state_d == StLost);
      update_q  <= accept;
      if (accept) begin
        xr_q <= x_s;
        yr_q <= y_s;
      end
      if (reject && rx_q != 8'hFF) rx_q <= rx_q + 8'd1;
    end
  end

  assign xpos_out_local  = xl_q;
  assign ypos_out_local  = yl_q;
  assign xpos_out_remote = xr_q;
  assign ypos_out_remote = yr_q;
  assign remote_valid    = valid_q;
  assign link_lost       = lost_q;
  assign remote_update   = update_q;
  assign rx_errors       = rx_q;

endmodule
